// File: rtl/sram2d_arb_pkg.sv
// Shared types and default geometry for the 2D SRAM arbiter.
package sram2d_arb_pkg;

  localparam int unsigned DefRowW         = 6;
  localparam int unsigned DefColW         = 6;
  localparam int unsigned DefDataW        = 8;
  localparam int unsigned DefAccessCycles = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold
  } arb_state_e;

  typedef struct packed {
    logic                rw;
    logic [DefRowW-1:0]  row;
    logic [DefColW-1:0]  col;
    logic [DefDataW-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter, round-robin by default.
// Define SRAM2D_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead.
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef SRAM2D_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end
`else
  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = {valid1, valid0};
    end
  end
`endif

endmodule

// File: rtl/sram2d_arbiter.sv
// Two-port arbiter and setup/strobe/hold sequencer for an asynchronous 2D SRAM.
// Build option SRAM2D_ARB_FIXED_PRIO_EN selects fixed priority in rr_arbiter2.
module sram2d_arbiter
  import sram2d_arb_pkg::*;
#(
  parameter int unsigned ROW_W         = DefRowW,
  parameter int unsigned COL_W         = DefColW,
  parameter int unsigned DATA_W        = DefDataW,
  parameter int unsigned ACCESS_CYCLES = DefAccessCycles
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_rw,
  input  logic [ROW_W-1:0]  req0_row,
  input  logic [COL_W-1:0]  req0_col,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_rw,
  input  logic [ROW_W-1:0]  req1_row,
  input  logic [COL_W-1:0]  req1_col,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,

  output logic              sram_cs_n,
  output logic              sram_rw,
  output logic [ROW_W-1:0]  sram_row,
  output logic [COL_W-1:0]  sram_col,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  arb_state_e      state_q;
  logic            init_q;
  logic            last_grant_q;
  logic            owner_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      grant;

  rr_arbiter2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // init_q keeps ready low for the first clock after reset release.
  assign req0_ready = init_q & (state_q == StIdle) & grant[0];
  assign req1_ready = init_q & (state_q == StIdle) & grant[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      init_q       <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      sram_cs_n    <= 1'b1;
      sram_rw      <= 1'b1;
      sram_row     <= '0;
      sram_col     <= '0;
      sram_wdata   <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_rdata   <= '0;
      rsp1_rdata   <= '0;
    end else begin
      init_q     <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0_ready) begin
            sram_rw      <= req0_rw;
            sram_row     <= req0_row;
            sram_col     <= req0_col;
            sram_wdata   <= req0_wdata;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            state_q      <= StSetup;
          end else if (req1_ready) begin
            sram_rw      <= req1_rw;
            sram_row     <= req1_row;
            sram_col     <= req1_col;
            sram_wdata   <= req1_wdata;
            owner_q      <= 1'b1;
            last_grant_q <= 1'b1;
            state_q      <= StSetup;
          end
        end
        StSetup: begin
          sram_cs_n <= 1'b0;
          cnt_q     <= CntW'(ACCESS_CYCLES - 1);
          state_q   <= StAccess;
        end
        StAccess: begin
          if (cnt_q == '0) begin
            sram_cs_n <= 1'b1;
            state_q   <= StHold;
            // Read data is sampled while cs_n is still low.
            if (owner_q) begin
              rsp1_valid <= 1'b1;
              rsp1_rdata <= sram_rw ? sram_rdata : '0;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_rdata <= sram_rw ? sram_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          sram_rw <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
